alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Sequencing wrapper that shares one `alu` instance between two requesters. Each requester presents operands and a 4-bit opcode on a valid/ready channel. A round-robin arbiter grants one request at a time, and the block registers the operands into the ALU. It then captures result and flags into a response register and holds them on a single tagged response channel until consumed. It sits between instruction-issue logic and the shared ALU datapath.

## Interface
Parameters:
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  32  operands
- req0_op  in  4  ALU control code
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the operation
- rsp_result  out  32  ALU result
- rsp_carry, rsp_overflow, rsp_zero  out  1 each  ALU flags
- rsp_illegal  out  1  opcode was 9..15
- busy  out  1  state != IDLE
- ops_done  out  CNT_W  count of completed responses

## Operation
- Opcodes are passed straight to the ALU control input:
  - 0 add, 1 sub, 2 and, 3 xor, 4 or, 5 sll, 6 srl, 7 slt, 8 sltu.
  - 9..15 yield result 0 from the ALU and set rsp_illegal.
- Flags are forwarded from the ALU unchanged; the block applies no flag logic of its own.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: arbitrate.
    - If the granted requester's valid=1, assert that requester's ready combinationally (the other ready=0).
    - On the clock edge: latch a, b, op, id; update last_grant; go to EXEC.
    - If neither valid=1, stay in IDLE.
  - EXEC: ALU operates on the latched operands. On the next edge, capture result, flags, illegal and id into the response register; go to RESP.
  - RESP: rsp_valid=1. When rsp_ready=1: increment ops_done, go to IDLE.
- Both ready outputs are 0 outside IDLE.
- Arbitration:
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Response fields are stable while rsp_valid=1 and not yet consumed.
- Requesters may change or drop inputs freely once ready was seen; the latched copy is used.
- ops_done wraps from all-ones to 0.

## Timing
- Reset values: state IDLE, last_grant=1, ops_done=0, rsp_* = 0, rsp_valid=0, busy=0.
  - While rst=1, both ready outputs = 0.
- Latency:
  - Accept at edge N.
  - rsp_valid=1 from after edge N+1.
  - Earliest consume at edge N+2.
  - Next accept at edge N+3 at the earliest.
- Throughput: at most one operation per 3 cycles.
- A request presented while busy is stalled, not dropped. The requester must hold valid and its payload until ready.
- A valid/ready pair at a clock edge is a transfer, and only one transfer happens per IDLE cycle.
- rsp_ready asserted with rsp_valid=0 has no effect.
- Reset during EXEC or RESP aborts the operation: no response is issued and ops_done does not increment.

## Test plan
- Reset, then req0 add a=0xFFFFFFFF b=1 -> req0_ready 1 cycle. rsp_valid 1 after two edges: result 0x00000000, carry=1, zero=1, rsp_id=0, ops_done=1.
- req1 add a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1, carry=0, zero=0, rsp_id=1.
- Both requesters valid continuously after reset (req0 xor 0xF0F0F0F0^0xFFFF0000, req1 sll 1<<4) -> grants alternate 0,1,0,1. Results 0x0F0FF0F0 and 0x00000010.
- rsp_ready held 0 for 5 cycles with req0 valid -> rsp fields stable, req0_ready stays 0, busy=1. Release -> req0 is accepted on the following IDLE cycle.
- op=12 -> result 0, rsp_illegal=1, zero=1. slt a=0xFFFFFFFF b=1 -> result 1. sltu with the same operands -> result 0.
- rst pulsed during EXEC -> no rsp_valid, ops_done=0, last_grant=1. Next tie grants req0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin wrapper that shares one ALU between two valid/ready requesters
// and returns each result on a single tagged response channel.

module alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  ctrl,
   output logic [31:0] result,
   output logic        carry,
   output logic        overflow,
   output logic        zero
);

   logic [32:0] sum;
   logic [32:0] diff;

   always_comb begin
      sum      = {1'b0, a} + {1'b0, b};
      diff     = {1'b0, a} - {1'b0, b};
      result   = 32'h0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (ctrl)
         4'd0: begin
            result   = sum[31:0];
            carry    = sum[32];
            overflow = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         4'd1: begin
            // carry reports the unsigned borrow of a - b
            result   = diff[31:0];
            carry    = diff[32];
            overflow = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         4'd2: result = a & b;
         4'd3: result = a ^ b;
         4'd4: result = a | b;
         4'd5: result = a << b[4:0];
         4'd6: result = a >> b[4:0];
         4'd7: result = {31'h0, $signed(a) < $signed(b)};
         4'd8: result = {31'h0, a < b};
         default: result = 32'h0;
      endcase
      zero = (result == 32'h0);
   end

endmodule

module alu_share_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [3:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [3:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [31:0]      rsp_result,
   output logic             rsp_carry,
   output logic             rsp_overflow,
   output logic             rsp_zero,
   output logic             rsp_illegal,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state;
   state_t      next_state;
   logic        last_grant;
   logic        grant_id;
   logic        any_valid;
   logic        accept;
   logic [31:0] lat_a;
   logic [31:0] lat_b;
   logic [3:0]  lat_op;
   logic        lat_id;
   logic [31:0] alu_result;
   logic        alu_carry;
   logic        alu_overflow;
   logic        alu_zero;

   alu u_alu (
      .a        (lat_a),
      .b        (lat_b),
      .ctrl     (lat_op),
      .result   (alu_result),
      .carry    (alu_carry),
      .overflow (alu_overflow),
      .zero     (alu_zero)
   );

   // On a tie the requester that did not win last time is granted
   always_comb begin
      any_valid = req0_valid | req1_valid;
      grant_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state)
         IDLE: begin
            if (any_valid && !rst) begin
               accept     = 1'b1;
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               next_state = EXEC;
            end
         end
         EXEC:    next_state = RESP;
         RESP:    if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign rsp_valid = (state == RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant   <= 1'b1;
         lat_a        <= 32'h0;
         lat_b        <= 32'h0;
         lat_op       <= 4'h0;
         lat_id       <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_result   <= 32'h0;
         rsp_carry    <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_illegal  <= 1'b0;
         ops_done     <= '0;
      end else begin
         if (accept) begin
            lat_a      <= grant_id ? req1_a  : req0_a;
            lat_b      <= grant_id ? req1_b  : req0_b;
            lat_op     <= grant_id ? req1_op : req0_op;
            lat_id     <= grant_id;
            last_grant <= grant_id;
         end
         if (state == EXEC) begin
            rsp_id       <= lat_id;
            rsp_result   <= alu_result;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
            rsp_illegal  <= (lat_op > 4'd8);
         end
         if (state == RESP && rsp_ready)
            ops_done <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter: reset, flags, round-robin,
// response backpressure, illegal/compare opcodes and reset abort.

module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic [3:0]  req0_op;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic [3:0]  req1_op;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_carry, rsp_overflow, rsp_zero, rsp_illegal;
   logic        busy;
   logic [15:0] ops_done;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_a       (req0_a),
      .req0_b       (req0_b),
      .req0_op      (req0_op),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_a       (req1_a),
      .req1_b       (req1_b),
      .req1_op      (req1_op),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_result   (rsp_result),
      .rsp_carry    (rsp_carry),
      .rsp_overflow (rsp_overflow),
      .rsp_zero     (rsp_zero),
      .rsp_illegal  (rsp_illegal),
      .busy         (busy),
      .ops_done     (ops_done)
   );

   // Drives one request from requester 0 and leaves the DUT in RESP
   task automatic run_op0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      @(negedge clk);
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 32'h0; req0_b = 32'h0; req0_op = 4'd0;
      req1_valid = 1'b1; req1_a = 32'h0; req1_b = 32'h0; req1_op = 4'd0;
      @(negedge clk); #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00)
         $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
      else passed++;
      checks++;
      if ({rsp_valid, busy} !== 2'b00 || ops_done !== 16'd0 || rsp_result !== 32'h0)
         $display("[TB] FAIL reset_state: got valid=%b busy=%b ops=%0d res=%h expected 0/0/0/0",
                  rsp_valid, busy, ops_done, rsp_result);
      else passed++;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_carry();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'hFFFFFFFF; req0_b = 32'h1; req0_op = 4'd0;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10)
         $display("[TB] FAIL add_ready: got %b expected 10", {req0_ready, req1_ready});
      else passed++;
      @(negedge clk);
      req0_valid = 1'b0; #1;
      checks++;
      if ({busy, rsp_valid, req0_ready} !== 3'b100)
         $display("[TB] FAIL add_exec: got busy/valid/ready=%b expected 100", {busy, rsp_valid, req0_ready});
      else passed++;
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_carry !== 1'b1 || rsp_zero !== 1'b1 ||
          rsp_overflow !== 1'b0 || rsp_id !== 1'b0)
         $display("[TB] FAIL add_rsp: got v=%b res=%h c=%b z=%b o=%b id=%b expected 1 00000000 1 1 0 0",
                  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_overflow, rsp_id);
      else passed++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd1)
         $display("[TB] FAIL add_consume: got v=%b busy=%b ops=%0d expected 0 0 1", rsp_valid, busy, ops_done);
      else passed++;
   endtask

   task automatic test_overflow();
      @(negedge clk);
      req1_valid = 1'b1; req1_a = 32'h7FFFFFFF; req1_b = 32'h1; req1_op = 4'd0;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01)
         $display("[TB] FAIL ovf_ready: got %b expected 01", {req0_ready, req1_ready});
      else passed++;
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (rsp_result !== 32'h80000000 || rsp_overflow !== 1'b1 || rsp_carry !== 1'b0 ||
          rsp_zero !== 1'b0 || rsp_id !== 1'b1)
         $display("[TB] FAIL ovf_rsp: got res=%h o=%b c=%b z=%b id=%b expected 80000000 1 0 0 1",
                  rsp_result, rsp_overflow, rsp_carry, rsp_zero, rsp_id);
      else passed++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; #1;
      checks++;
      if (ops_done !== 16'd2)
         $display("[TB] FAIL ovf_count: got %0d expected 2", ops_done);
      else passed++;
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_ready [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
      logic [31:0] exp_res   [4] = '{32'h0F0FF0F0, 32'h00000010, 32'h0F0FF0F0, 32'h00000010};
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'hF0F0F0F0; req0_b = 32'hFFFF0000; req0_op = 4'd3;
      req1_valid = 1'b1; req1_a = 32'h1;        req1_b = 32'h4;        req1_op = 4'd5;
      rsp_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({req0_ready, req1_ready} !== exp_ready[i])
            $display("[TB] FAIL rr_grant%0d: got %b expected %b", i, {req0_ready, req1_ready}, exp_ready[i]);
         else passed++;
         @(negedge clk);
         @(negedge clk); #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_result !== exp_res[i] || rsp_id !== exp_ready[i][0])
            $display("[TB] FAIL rr_rsp%0d: got v=%b res=%h id=%b expected 1 %h %b",
                     i, rsp_valid, rsp_result, rsp_id, exp_res[i], exp_ready[i][0]);
         else passed++;
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      #1;
      checks++;
      if (ops_done !== 16'd6)
         $display("[TB] FAIL rr_count: got %0d expected 6", ops_done);
      else passed++;
   endtask

   task automatic test_back_pressure();
      int bad = 0;
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'h000000F0; req0_b = 32'h00000F00; req0_op = 4'd4;
      @(negedge clk);
      req0_a = 32'h1; req0_b = 32'h3; req0_op = 4'd2;
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'h00000FF0 || rsp_id !== 1'b0)
         $display("[TB] FAIL bp_rsp: got v=%b res=%h id=%b expected 1 00000ff0 0", rsp_valid, rsp_result, rsp_id);
      else passed++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         if (rsp_valid !== 1'b1 || rsp_result !== 32'h00000FF0 || req0_ready !== 1'b0 || busy !== 1'b1)
            bad++;
      end
      checks++;
      if (bad != 0)
         $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", bad);
      else passed++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; #1;
      checks++;
      if (req0_ready !== 1'b1 || ops_done !== 16'd7)
         $display("[TB] FAIL bp_accept: got ready=%b ops=%0d expected 1 7", req0_ready, ops_done);
      else passed++;
      @(negedge clk);
      req0_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (rsp_result !== 32'h1 || rsp_id !== 1'b0)
         $display("[TB] FAIL bp_second: got res=%h id=%b expected 00000001 0", rsp_result, rsp_id);
      else passed++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_illegal_compare();
      rsp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk); #1;
      checks++;
      if (ops_done !== 16'd8 || rsp_valid !== 1'b0)
         $display("[TB] FAIL idle_ready: got ops=%0d v=%b expected 8 0", ops_done, rsp_valid);
      else passed++;
      rsp_ready = 1'b0;
      run_op0(32'h5, 32'h3, 4'd12);
      checks++;
      if (rsp_result !== 32'h0 || rsp_illegal !== 1'b1 || rsp_zero !== 1'b1)
         $display("[TB] FAIL illegal: got res=%h ill=%b z=%b expected 00000000 1 1", rsp_result, rsp_illegal, rsp_zero);
      else passed++;
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
      run_op0(32'hFFFFFFFF, 32'h1, 4'd7);
      checks++;
      if (rsp_result !== 32'h1 || rsp_illegal !== 1'b0)
         $display("[TB] FAIL slt: got res=%h ill=%b expected 00000001 0", rsp_result, rsp_illegal);
      else passed++;
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
      run_op0(32'hFFFFFFFF, 32'h1, 4'd8);
      checks++;
      if (rsp_result !== 32'h0 || rsp_zero !== 1'b1)
         $display("[TB] FAIL sltu: got res=%h z=%b expected 00000000 1", rsp_result, rsp_zero);
      else passed++;
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0; #1;
      checks++;
      if (ops_done !== 16'd11)
         $display("[TB] FAIL cmp_count: got %0d expected 11", ops_done);
      else passed++;
   endtask

   task automatic test_reset_abort();
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'h2; req0_b = 32'h2; req0_op = 4'd0;
      @(negedge clk);
      req0_valid = 1'b0; rst = 1'b1; #1;
      checks++;
      if (busy !== 1'b0 || ops_done !== 16'd0 || rsp_valid !== 1'b0)
         $display("[TB] FAIL abort_state: got busy=%b ops=%0d v=%b expected 0 0 0", busy, ops_done, rsp_valid);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      req0_valid = 1'b1; req0_a = 32'h3; req0_b = 32'h4; req0_op = 4'd0;
      req1_valid = 1'b1; req1_a = 32'h9; req1_b = 32'h9; req1_op = 4'd0;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10 || rsp_valid !== 1'b0)
         $display("[TB] FAIL abort_tie: got ready=%b v=%b expected 10 0", {req0_ready, req1_ready}, rsp_valid);
      else passed++;
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (rsp_result !== 32'h7 || rsp_id !== 1'b0 || ops_done !== 16'd0)
         $display("[TB] FAIL abort_next: got res=%h id=%b ops=%0d expected 00000007 0 0", rsp_result, rsp_id, ops_done);
      else passed++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; #1;
      checks++;
      if (ops_done !== 16'd1)
         $display("[TB] FAIL abort_count: got %0d expected 1", ops_done);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_add_carry();
      test_overflow();
      test_round_robin();
      test_back_pressure();
      test_illegal_compare();
      test_reset_abort();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
